// File: rtl/tx_handshake.sv
// tx_handshake: core-to-TX FIFO presenting packets over a return-to-zero valid/ready handshake
module tx_handshake #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int PTR_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rc_tx_push,
    input  logic [DATA_WIDTH-1:0] rc_tx_data,
    output logic                  rc_tx_ready,
    output logic                  tx_done,
    output logic                  tx_overflow,
    output logic [DATA_WIDTH-1:0] TX_Data,
    output logic                  TX_Data_Valid,
    input  logic                  TX_Data_Ready
);
    typedef enum logic [1:0] {RST, IDLE, SEND, RELEASE} state_t;
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        count;
    logic                  pop, push_ok;
    assign pop         = (state == SEND) && TX_Data_Ready;
    assign push_ok     = rc_tx_push && ((count != FULL) || pop);
    assign rc_tx_ready = count != FULL;
    assign TX_Data     = mem[rd_ptr];
    always_ff @(posedge clk)
        if (push_ok) mem[wr_ptr] <= rc_tx_data;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RST;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            tx_done       <= 1'b0;
            tx_overflow   <= 1'b0;
            TX_Data_Valid <= 1'b0;
        end else begin
            tx_done     <= 1'b0;
            tx_overflow <= tx_overflow | (rc_tx_push & ~push_ok);
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= (push_ok && !pop) ? count + (PTR_W+1)'(1) :
                     (pop && !push_ok) ? count - (PTR_W+1)'(1) : count;
            case (state)
                RST:     if (!TX_Data_Ready) state <= IDLE;
                IDLE:    if (count != '0) begin
                             state         <= SEND;
                             TX_Data_Valid <= 1'b1;
                         end
                SEND:    if (TX_Data_Ready) begin
                             state         <= RELEASE;
                             TX_Data_Valid <= 1'b0;
                             tx_done       <= 1'b1;
                         end
                RELEASE: if (!TX_Data_Ready) state <= IDLE;
                default: state <= RST;
            endcase
        end
    end
endmodule
